// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Access sizes, FSM states and a byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    MERGE,
    WRITE,
    RESP
  } dmem_state_t;

  function automatic logic [3:0] size_bytes(
    mem_size_t s
  );
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data-memory responder:
// load extraction with sign/zero extension and store merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [63:0] merged
);

  logic [63:0] sh;
  logic [7:0]  bmask;
  logic [63:0] mask;

  always_comb begin
    sh = dword >> {offset, 3'b000};
    rdata = sh;
    unique case (size)
      SZ_B:
        rdata = is_unsigned
          ? {56'd0, sh[7:0]}
          : {{56{sh[7]}}, sh[7:0]};
      SZ_H:
        rdata = is_unsigned
          ? {48'd0, sh[15:0]}
          : {{48{sh[15]}}, sh[15:0]};
      SZ_W:
        rdata = is_unsigned
          ? {32'd0, sh[31:0]}
          : {{32{sh[31]}}, sh[31:0]};
      SZ_D:
        rdata = sh;
    endcase
  end

  // Byte enables cover offset..offset+2^size-1.
  always_comb begin
    bmask = 8'(((16'd1 << size_bytes(size))
              - 16'd1) << offset);
    mask = '0;
    for (int i = 0; i < 8; i++)
      mask[8*i +: 8] = {8{bmask[i]}};
    merged = (dword & ~mask)
           | ((wdata << {offset, 3'b000}) & mask);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time.
// DMEM_MISALIGN_TRAP_EN: misaligned requests return rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = $clog2(DEPTH);

  logic [63:0] mem [DEPTH];

  dmem_state_t   state;
  logic [2:0]    cnt;
  logic [IW-1:0] idx_q;
  logic [2:0]    off_q;
  mem_size_t     size_q;
  logic          write_q;
  logic          uns_q;
  logic [63:0]   wdata_q;
  logic [63:0]   line_q;

  mem_size_t   sz;
  logic [63:0] addr_al;
  logic [63:0] load_data;
  logic [63:0] merged;
  logic        addr_unused;

  assign sz = mem_size_t'(req_size);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis;
  assign mis = |(req_addr[2:0]
               & 3'(size_bytes(sz) - 4'd1));
  assign addr_al = req_addr;
`else
  assign addr_al = req_addr
                 & ~64'(size_bytes(sz) - 4'd1);
`endif

  assign addr_unused = ^addr_al[63:IW+3];

  dmem_lane_align u_align (
    .dword       (mem[idx_q]),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      size_q    <= SZ_B;
      write_q   <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      line_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            size_q    <= sz;
            uns_q     <= req_unsigned;
            wdata_q   <= req_wdata;
            idx_q     <= addr_al[IW+2:3];
            off_q     <= addr_al[2:0];
`ifdef DMEM_MISALIGN_TRAP_EN
            if (mis) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else
`endif
            if (req_write && sz == SZ_D) begin
              state  <= WRITE;
              line_q <= req_wdata;
            end else begin
              state <= RD_WAIT;
              cnt   <= 3'(READ_LAT - 1);
            end
          end
        end
        RD_WAIT: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else if (write_q) begin
            state <= MERGE;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= 1'b0;
          end
        end
        MERGE: begin
          line_q <= merged;
          state  <= WRITE;
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a write only lands in WRITE.
  always_ff @(posedge clock) begin
    if (state == WRITE)
      mem[idx_q] <= line_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder.
// Honours DMEM_MISALIGN_TRAP_EN for misaligned expectations.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int RL    = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [63:0] E_LW12_R = 64'h0;
  localparam logic        E_LW12_E = 1'b1;
  localparam int          E_LW12_L = 1;
  localparam logic        E_SW13_E = 1'b1;
  localparam int          E_SW13_L = 1;
  localparam logic [63:0] E_AFTER  = 64'hCDEF66554433AB11;
`else
  localparam logic [63:0] E_LW12_R = 64'h000000004433AB11;
  localparam logic        E_LW12_E = 1'b0;
  localparam int          E_LW12_L = RL + 1;
  localparam logic        E_SW13_E = 1'b0;
  localparam int          E_SW13_L = RL + 3;
  localparam logic [63:0] E_AFTER  = 64'hCDEF665512345678;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  always #5 clock = ~clock;

  dmem_responder #(
    .DEPTH    (DEPTH),
    .READ_LAT (RL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   accepts = 0;
  bit   prev_v = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock)
    if (!reset && req_valid && req_ready)
      accepts <= accepts + 1;

  always @(posedge clock) begin
    exp_t e;
    int   lat;
    #1;
    if (!reset) begin
      if (rsp_valid) begin
        vectors++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp rdata=%h err=%b",
                   rsp_rdata, rsp_err);
        end else begin
          e = sbq.pop_front();
          lat = cyc - e.acc + 1;
          if (rsp_rdata !== e.rdata || rsp_err !== e.err
              || lat != e.lat || req_ready !== 1'b0) begin
            errors++;
            $display({"FAIL rsp got rdata=%h err=%b lat=%0d",
                      " rdy=%b want %h %b %0d 0"},
                     rsp_rdata, rsp_err, lat, req_ready,
                     e.rdata, e.err, e.lat);
          end
        end
      end else if (prev_v) begin
        vectors++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_rsp got %b want 1",
                   req_ready);
        end
      end
    end
    prev_v = rsp_valid;
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input bit wr,
                       input logic [1:0] sz,
                       input bit uns,
                       input logic [63:0] a,
                       input logic [63:0] wd,
                       input bit hold,
                       input bit chk,
                       input logic [63:0] er,
                       input logic ee,
                       input int el);
    int n = 0;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
      return;
    end
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    if (chk) sbq.push_back('{er, ee, el, cyc + 1});
    @(negedge clock);
    if (hold) begin
      req_addr  = ~a;
      req_wdata = 64'hDEADBEEF0BADF00D;
      req_size  = ~sz;
      req_write = ~wr;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic load(input logic [1:0] sz,
                      input bit uns,
                      input logic [63:0] a,
                      input logic [63:0] ev);
    issue(1'b0, sz, uns, a, '0, 1'b0, 1'b1,
          ev, 1'b0, RL + 1);
  endtask

  task automatic store(input logic [1:0] sz,
                       input logic [63:0] a,
                       input logic [63:0] wd);
    issue(1'b1, sz, 1'b0, a, wd, 1'b0, 1'b1,
          '0, 1'b0, (sz == 2'd3) ? 2 : RL + 3);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clock);
    while ((sbq.size() != 0 || !req_ready) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0 || !req_ready) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0",
               sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int a0;
    #1 reset = 1'b1;
    #2;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    store(2'd3, 64'h10, 64'h8877665544332211);
    load(2'd3, 1'b0, 64'h10, 64'h8877665544332211);
    load(2'd0, 1'b0, 64'h17, 64'hFFFFFFFFFFFFFF88);
    load(2'd0, 1'b1, 64'h17, 64'h0000000000000088);
    load(2'd1, 1'b0, 64'h12, 64'h0000000000004433);
    load(2'd2, 1'b0, 64'h14, 64'hFFFFFFFF88776655);
    load(2'd2, 1'b1, 64'h14, 64'h0000000088776655);

    store(2'd0, 64'h11, 64'h00000000000000AB);
    load(2'd3, 1'b0, 64'h10, 64'h887766554433AB11);
    store(2'd1, 64'h16, 64'h000000000000CDEF);
    load(2'd3, 1'b0, 64'h10, 64'hCDEF66554433AB11);

    issue(1'b0, 2'd2, 1'b0, 64'h12, '0, 1'b0, 1'b1,
          E_LW12_R, E_LW12_E, E_LW12_L);
    issue(1'b1, 2'd2, 1'b0, 64'h13, 64'h12345678,
          1'b0, 1'b1, '0, E_SW13_E, E_SW13_L);
    load(2'd3, 1'b0, 64'h10, E_AFTER);
    drain();

    a0 = accepts;
    issue(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788,
          1'b1, 1'b1, '0, 1'b0, 2);
    issue(1'b0, 2'd1, 1'b1, 64'h1E, '0, 1'b1, 1'b1,
          64'h1122, 1'b0, RL + 1);
    issue(1'b0, 2'd0, 1'b0, 64'h18, '0, 1'b0, 1'b1,
          64'hFFFFFFFFFFFFFF88, 1'b0, RL + 1);
    drain();
    check("hold_accepts", 64'(accepts - a0), 64'd3);

    store(2'd3, 64'h20, 64'h0102030405060708);
    drain();
    issue(1'b1, 2'd0, 1'b0, 64'h20, 64'hFF,
          1'b0, 1'b0, '0, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (RL + 4) @(negedge clock);
    check("midrst_idle_ready", 64'(req_ready), 64'd1);
    load(2'd3, 1'b0, 64'h20, 64'h0102030405060708);
    load(2'd3, 1'b0, 64'h10 + 64'(8 * DEPTH), E_AFTER);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule
